// File: rtl/hilo_muldiv_if.sv
// Handshake and result bus between the execute stage and the HI/LO mul/div unit.
interface hilo_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Multiplies by shift-add and divides by restoring division on operand
// magnitudes, one bit per cycle, then applies sign correction in FIX.
module hilo_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  hilo_muldiv_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_NOP6  = 3'b110,
    OP_NOP7  = 3'b111
  } op_t;

  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div, r_div0, r_neg_q, r_neg_r;
  logic [WIDTH-1:0]   r_a_raw;
  logic [2*WIDTH-1:0] r_mcand, r_prod;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_rem, r_quo, r_dsor;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done, r_dbz;

  op_t                w_op;
  logic               w_idle_req, w_accept, w_mt_hi, w_mt_lo;
  logic               w_signed, w_sign_a, w_sign_b;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [WIDTH:0]     w_shift, w_diff;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;

  // Request decode; flush in IDLE suppresses any start.
  always_comb begin
    w_op       = op_t'(bus.op);
    w_idle_req = (r_state == S_IDLE) && bus.start && !bus.flush;
    w_accept   = w_idle_req && (w_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
    w_mt_hi    = w_idle_req && (w_op == OP_MTHI);
    w_mt_lo    = w_idle_req && (w_op == OP_MTLO);
    w_signed   = (w_op == OP_MULT) || (w_op == OP_DIV);
    w_sign_a   = w_signed && bus.a[WIDTH-1];
    w_sign_b   = w_signed && bus.b[WIDTH-1];
    w_mag_a    = w_sign_a ? -bus.a : bus.a;
    w_mag_b    = w_sign_b ? -bus.b : bus.b;
  end

  // One restoring-division step and the final sign corrections.
  always_comb begin
    w_shift    = {r_rem, r_quo[WIDTH-1]};
    w_diff     = w_shift - {1'b0, r_dsor};
    w_prod_fix = r_neg_q ? -r_prod : r_prod;
    w_quo_fix  = r_neg_q ? -r_quo : r_quo;
    w_rem_fix  = r_neg_r ? -r_rem : r_rem;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: RUN holds one extra cycle after the last iteration so
  // that the total latency from accept to done is WIDTH+2.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_RUN;
      S_RUN: begin
        if (bus.flush)                  w_next = S_IDLE;
        else if (r_cnt == CW'(WIDTH))   w_next = S_FIX;
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand latch and per-cycle iteration datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_div0   <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_a_raw  <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dsor   <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_is_div <= bus.op[1];
      r_div0   <= bus.op[1] && (bus.b == '0);
      r_neg_q  <= w_sign_a ^ w_sign_b;
      r_neg_r  <= w_sign_a;
      r_a_raw  <= bus.a;
      r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
      r_mplier <= w_mag_b;
      r_prod   <= '0;
      r_rem    <= '0;
      r_quo    <= w_mag_a;
      r_dsor   <= w_mag_b;
    end else if (r_state == S_RUN && r_cnt != CW'(WIDTH)) begin
      r_cnt <= r_cnt + CW'(1);
      if (!r_is_div) begin
        if (r_mplier[0]) r_prod <= r_prod + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end else if (!r_div0) begin
        if (!w_diff[WIDTH]) begin
          r_rem <= w_diff[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], 1'b1};
        end else begin
          r_rem <= w_shift[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  // Architectural HI/LO, done pulse and sticky divide-by-zero flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_mt_hi) r_hi <= bus.a;
      if (w_mt_lo) r_lo <= bus.a;
      if (r_state == S_FIX && !bus.flush) begin
        r_done <= 1'b1;
        if (!r_is_div) begin
          {r_hi, r_lo} <= w_prod_fix;
        end else if (r_div0) begin
          r_hi  <= r_a_raw;
          r_lo  <= '1;
          r_dbz <= 1'b1;
        end else begin
          r_hi  <= w_rem_fix;
          r_lo  <= w_quo_fix;
          r_dbz <= 1'b0;
        end
      end
    end
  end

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_hilo_muldiv_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hilo_muldiv_if #(.WIDTH(32)) bus32 ();
  hilo_muldiv_if #(.WIDTH(8))  bus8 ();

  hilo_muldiv_unit #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
  hilo_muldiv_unit #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));

  logic        st [2];
  logic [2:0]  opv [2];
  logic [31:0] av [2];
  logic [31:0] bv [2];
  logic        fl [2];

  logic [31:0] hi_v [2];
  logic [31:0] lo_v [2];
  logic        busy_v [2];
  logic        done_v [2];
  logic        dz_v [2];

  assign bus32.start = st[0];
  assign bus32.op    = opv[0];
  assign bus32.a     = av[0];
  assign bus32.b     = bv[0];
  assign bus32.flush = fl[0];
  assign bus8.start  = st[1];
  assign bus8.op     = opv[1];
  assign bus8.a      = av[1][7:0];
  assign bus8.b      = bv[1][7:0];
  assign bus8.flush  = fl[1];

  assign hi_v[0]   = bus32.hi;
  assign lo_v[0]   = bus32.lo;
  assign busy_v[0] = bus32.busy;
  assign done_v[0] = bus32.done;
  assign dz_v[0]   = bus32.div_by_zero;
  assign hi_v[1]   = {24'd0, bus8.hi};
  assign lo_v[1]   = {24'd0, bus8.lo};
  assign busy_v[1] = bus8.busy;
  assign done_v[1] = bus8.done;
  assign dz_v[1]   = bus8.div_by_zero;

  typedef enum int {K_MD, K_MT} kind_e;

  typedef struct {
    kind_e       kind;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          hi_en;
    bit          lo_en;
    bit          is_div;
    bit          dz;
    int          acc;
    int          due;
  } item_t;

  item_t       sb [2][$];
  logic [31:0] mhi [2];
  logic [31:0] mlo [2];
  bit          mdz [2];
  int          n_cmp  = 0;
  int          n_fail = 0;

  function automatic int wof(int i);
    return (i == 0) ? 32 : 8;
  endfunction

  // Reference: plain signed/unsigned arithmetic on w-bit operands.
  function automatic item_t model(int w, logic [2:0] op, logic [31:0] a, logic [31:0] b);
    item_t       it;
    logic [63:0] m, ua, ub, up;
    longint      sa, sbv, q, r;
    m  = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & m;
    ub = {32'd0, b} & m;
    sa  = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    sbv = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    it.kind = K_MD; it.hi_en = 1'b1; it.lo_en = 1'b1; it.is_div = 1'b0; it.dz = 1'b0;
    it.acc = 0; it.due = 0; it.hi = '0; it.lo = '0;
    case (op)
      3'd0: begin
        up = 64'(sa * sbv);
        it.hi = 32'((up >> w) & m); it.lo = 32'(up & m);
      end
      3'd1: begin
        up = ua * ub;
        it.hi = 32'((up >> w) & m); it.lo = 32'(up & m);
      end
      3'd2, 3'd3: begin
        it.is_div = 1'b1;
        if (ub == 64'd0) begin
          it.dz = 1'b1; it.hi = 32'(ua); it.lo = 32'(m);
        end else if (op == 3'd2) begin
          q = sa / sbv; r = sa % sbv;
          it.lo = 32'(64'(q) & m); it.hi = 32'(64'(r) & m);
        end else begin
          it.lo = 32'(ua / ub); it.hi = 32'(ua % ub);
        end
      end
      3'd4: begin it.kind = K_MT; it.hi = 32'(ua); it.lo_en = 1'b0; end
      3'd5: begin it.kind = K_MT; it.lo = 32'(ua); it.hi_en = 1'b0; end
      default: begin it.kind = K_MT; it.hi_en = 1'b0; it.lo_en = 1'b0; end
    endcase
    return it;
  endfunction

  task automatic check(string nm, int i, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (W=%0d, cycle %0d): actual=%0h required=%0h", nm, wof(i), cyc, act, exp);
    end
  endtask

  task automatic monitor_step(int i);
    item_t it;
    bit    exp_busy;
    if (rst) begin
      check("reset_hi", i, hi_v[i], 0);
      check("reset_lo", i, lo_v[i], 0);
      check("reset_busy_done_dz", i, {busy_v[i], done_v[i], dz_v[i]}, 0);
      mhi[i] = '0; mlo[i] = '0; mdz[i] = 1'b0;
      sb[i].delete();
    end else begin
      if (done_v[i]) begin
        if (sb[i].size() == 0 || sb[i][0].kind != K_MD) begin
          check("unexpected_done", i, 64'(done_v[i]), 0);
        end else begin
          it = sb[i].pop_front();
          mhi[i] = it.hi;
          mlo[i] = it.lo;
          if (it.is_div) mdz[i] = it.dz;
          check("latency", i, 64'(cyc), 64'(it.due));
        end
      end else if (sb[i].size() != 0 && cyc >= sb[i][0].due) begin
        if (sb[i][0].kind == K_MD) begin
          check("done_timeout", i, 64'(done_v[i]), 1);
          void'(sb[i].pop_front());
        end else begin
          it = sb[i].pop_front();
          if (it.hi_en) mhi[i] = it.hi;
          if (it.lo_en) mlo[i] = it.lo;
        end
      end
      exp_busy = (sb[i].size() != 0) && (sb[i][0].kind == K_MD) && (cyc >= sb[i][0].acc);
      check("hi", i, hi_v[i], mhi[i]);
      check("lo", i, lo_v[i], mlo[i]);
      check("div_by_zero", i, 64'(dz_v[i]), 64'(mdz[i]));
      check("busy", i, 64'(busy_v[i]), 64'(exp_busy));
    end
  endtask

  initial begin
    mhi[0] = '0; mhi[1] = '0; mlo[0] = '0; mlo[1] = '0; mdz[0] = 1'b0; mdz[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) monitor_step(i);
    end
  end

  // Called at a negedge; holds start for exactly one clock.
  task automatic issue(int i, logic [2:0] op, logic [31:0] a, logic [31:0] b, bit push);
    item_t it;
    st[i] = 1'b1; opv[i] = op; av[i] = a; bv[i] = b;
    if (push) begin
      it = model(wof(i), op, a, b);
      it.acc = cyc + 1;
      it.due = (it.kind == K_MD) ? it.acc + wof(i) + 2 : it.acc;
      sb[i].push_back(it);
    end
    @(negedge clk);
    st[i] = 1'b0;
  endtask

  task automatic wait_idle(int i);
    for (int k = 0; k < 200; k++) begin
      if (!busy_v[i]) break;
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] pick(logic [31:0] m, logic [31:0] mn);
    logic [31:0] r;
    case ($urandom_range(0, 7))
      0: r = mn;
      1: r = m;
      2: r = '0;
      default: r = $urandom & m;
    endcase
    return r;
  endfunction

  task automatic run_suite(int i);
    int          w;
    logic [31:0] m, mn, ra, rb;
    logic [2:0]  rop;
    w  = wof(i);
    m  = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    mn = 32'd1 << (w - 1);

    issue(i, 3'd1, m, m, 1'b1);                       wait_idle(i);
    issue(i, 3'd0, (32'd0 - 32'd3) & m, 32'd5, 1'b1); wait_idle(i);
    issue(i, 3'd2, (32'd0 - 32'd7) & m, 32'd2, 1'b1); wait_idle(i);
    issue(i, 3'd3, 32'd100, 32'd0, 1'b1);             wait_idle(i);
    issue(i, 3'd3, 32'd100, 32'd7, 1'b1);             wait_idle(i);

    issue(i, 3'd4, 32'h1234_5678 & m, 32'd0, 1'b1);
    issue(i, 3'd5, 32'h9ABC_DEF0 & m, 32'd0, 1'b1);
    @(negedge clk);

    issue(i, 3'd1, 32'd6, 32'd7, 1'b1);
    repeat (3) @(negedge clk);
    issue(i, 3'd1, 32'd1, 32'd1, 1'b0);
    wait_idle(i);

    issue(i, 3'd2, mn, m, 1'b1); wait_idle(i);

    // Flush partway through a multiply.
    issue(i, 3'd1, $urandom & m, $urandom & m, 1'b1);
    repeat (8) @(negedge clk);
    fl[i] = 1'b1;
    @(posedge clk);
    #1 void'(sb[i].pop_back());
    @(negedge clk);
    fl[i] = 1'b0;

    // Flush in IDLE blocks a simultaneous MTHI; no-op codes change nothing.
    fl[i] = 1'b1;
    issue(i, 3'd4, 32'hDEAD_BEEF & m, 32'd0, 1'b0);
    fl[i] = 1'b0;
    issue(i, 3'd6, $urandom & m, $urandom & m, 1'b0);
    issue(i, 3'd7, $urandom & m, $urandom & m, 1'b0);
    @(negedge clk);

    for (int k = 0; k < 14; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = pick(m, mn);
      rb  = pick(m, mn);
      issue(i, rop, ra, rb, (rop < 3'd6));
      if (rop < 3'd4 && $urandom_range(0, 2) == 0) begin
        repeat (2) @(negedge clk);
        issue(i, 3'd4, $urandom & m, 32'd0, 1'b0);
      end
      wait_idle(i);
    end

    // Asynchronous reset in the middle of RUN.
    issue(i, 3'd1, m, m, 1'b1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    issue(i, 3'd1, 32'd9, 32'd11, 1'b1); wait_idle(i);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0; opv[i] = '0; av[i] = '0; bv[i] = '0; fl[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    run_suite(0);
    run_suite(1);
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
